// File: rtl/memory_handshake_unit.sv
// Memory with a wait-state handshake: MOV starts an access and MFC signals completion.
// Define MEM_SIGN_EXTEND_EN to honour SignedLoad on byte and halfword reads.
module memory_handshake_unit #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  DataSize,
  input  logic        SignedLoad,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mfc_q, mfc_d;
  logic [31:0] dout_q, dout_d;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic        capture;
  logic        mem_we;
  logic        load_signed;
  logic        ext;
  logic [7:0]  base, a1, a2, a3;
  logic [31:0] rdata;

  logic [7:0] mem [256];

`ifdef MEM_SIGN_EXTEND_EN
  logic signed_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      signed_q <= 1'b0;
    end else if (capture) begin
      signed_q <= SignedLoad;
    end
  end

  assign load_signed = signed_q;
`else
  logic unused_signed;

  assign unused_signed = SignedLoad;
  assign load_signed   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mfc_q   <= 1'b0;
      dout_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      dout_q  <= dout_d;
      if (capture) begin
        rw_q    <= RW;
        size_q  <= DataSize;
        addr_q  <= Address;
        wdata_q <= DataIn;
      end
    end
  end

  // Forced alignment: the low address bits are dropped for wider accesses.
  always_comb begin
    case (size_q)
      2'b00:   base = addr_q;
      2'b01:   base = {addr_q[7:1], 1'b0};
      default: base = {addr_q[7:2], 2'b00};
    endcase
  end

  assign a1 = base + 8'd1;
  assign a2 = base + 8'd2;
  assign a3 = base + 8'd3;

  // Big-endian: the lowest address holds the most significant byte.
  always_comb begin
    ext   = 1'b0;
    rdata = '0;
    case (size_q)
      2'b00: begin
        ext   = load_signed & mem[base][7];
        rdata = {{24{ext}}, mem[base]};
      end
      2'b01: begin
        ext   = load_signed & mem[base][7];
        rdata = {{16{ext}}, mem[base], mem[a1]};
      end
      default: rdata = {mem[base], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mfc_d   = mfc_q;
    dout_d  = dout_q;
    capture = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MOV) begin
          capture = 1'b1;
          cnt_d   = WaitCnt;
          state_d = (WaitCnt == 4'd0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (!MOV) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = '0;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        mfc_d   = 1'b1;
        state_d = StDone;
        if (rw_q) begin
          dout_d = rdata;
        end else begin
          mem_we = 1'b1;
        end
      end
      StDone: begin
        if (!MOV) begin
          mfc_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage has no reset so contents survive Reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      case (size_q)
        2'b00: mem[base] <= wdata_q[7:0];
        2'b01: begin
          mem[base] <= wdata_q[15:8];
          mem[a1]   <= wdata_q[7:0];
        end
        default: begin
          mem[base] <= wdata_q[31:24];
          mem[a1]   <= wdata_q[23:16];
          mem[a2]   <= wdata_q[15:8];
          mem[a3]   <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;

endmodule
